// File: rtl/ahb_arbiter.sv
// ----------------------------------------------------------------------------
// ahb_arbiter
//   Round-robin AHB bus arbiter. Shares the bus between NUM_MASTERS requesters
//   (pixel-read master, result-write master, external host, ...), honouring
//   fixed-length bursts, locked transfers and slave wait states.
//
// Ports
//   ahb_hclk      in   bus clock, all state updates on rising edge
//   ahb_hreset    in   synchronous active-high reset
//   ahb_hbusreq   in   [NUM_MASTERS] per-master bus request
//   ahb_hlock     in   [NUM_MASTERS] per-master locked-transfer request
//   ahb_htrans    in   [2] transfer type of the address-phase master
//   ahb_hburst    in   [3] burst type of the address-phase master
//   ahb_hready    in   slave ready; transfers accepted only when 1
//   ahb_hgrant    out  [NUM_MASTERS] one-hot registered grant
//   ahb_hmaster   out  [MIDX_W] index of master owning the address phase
//   ahb_hmastlock out  current address-phase transfer is locked
// ----------------------------------------------------------------------------
module ahb_arbiter #(
   parameter int unsigned NUM_MASTERS    = 4,
   parameter int unsigned MIDX_W         = 2,
   parameter int unsigned DEFAULT_MASTER = 0
) (
   input  logic                   ahb_hclk,
   input  logic                   ahb_hreset,
   input  logic [NUM_MASTERS-1:0] ahb_hbusreq,
   input  logic [NUM_MASTERS-1:0] ahb_hlock,
   input  logic [1:0]             ahb_htrans,
   input  logic [2:0]             ahb_hburst,
   input  logic                   ahb_hready,
   output logic [NUM_MASTERS-1:0] ahb_hgrant,
   output logic [MIDX_W-1:0]      ahb_hmaster,
   output logic                   ahb_hmastlock
);

   // Informational arbitration state; outputs do not depend on it.
   localparam logic [1:0] ST_PARK  = 2'd0;
   localparam logic [1:0] ST_OWN   = 2'd1;
   localparam logic [1:0] ST_BURST = 2'd2;
   localparam logic [1:0] ST_LOCK  = 2'd3;

   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_BUSY   = 2'b01;
   localparam logic [1:0] TR_NONSEQ = 2'b10;
   localparam logic [1:0] TR_SEQ    = 2'b11;

   localparam logic [MIDX_W-1:0]      DEF_IDX = MIDX_W'(DEFAULT_MASTER);
   localparam logic [NUM_MASTERS-1:0] DEF_GNT = NUM_MASTERS'(1) << DEFAULT_MASTER;

   logic [NUM_MASTERS-1:0] r_grant;
   logic [MIDX_W-1:0]      r_owner;
   logic [MIDX_W-1:0]      r_rr_ptr;
   logic [4:0]             r_cnt;
   logic [MIDX_W-1:0]      r_hmaster;
   logic                   r_mastlock;
   logic [1:0]             r_state;

   logic [4:0]             w_len_m1;
   logic [4:0]             w_cnt_next;
   logic                   w_lock_hold;
   logic                   w_hold;
   logic                   w_any_req;
   logic [MIDX_W-1:0]      w_winner;
   logic [1:0]             w_state_next;

   // Remaining beats after the NONSEQ beat; INCR is treated like SINGLE so
   // undefined-length bursts never hold the bus.
   always_comb begin
      w_len_m1 = '0;
      case (ahb_hburst)
         3'b010, 3'b011: w_len_m1 = 5'd3;
         3'b100, 3'b101: w_len_m1 = 5'd7;
         3'b110, 3'b111: w_len_m1 = 5'd15;
         default:        w_len_m1 = '0;
      endcase
   end

   always_comb begin
      w_cnt_next = r_cnt;
      if (ahb_hready) begin
         case (ahb_htrans)
            TR_NONSEQ: w_cnt_next = w_len_m1;
            TR_SEQ:    w_cnt_next = (r_cnt != '0) ? r_cnt - 5'd1 : r_cnt;
            TR_IDLE:   w_cnt_next = '0;
            TR_BUSY:   w_cnt_next = r_cnt;
            default:   w_cnt_next = r_cnt;
         endcase
      end
   end

   // r_mastlock keeps the grant through the final locked transfer, i.e. one
   // accepted transfer after the owner drops its lock request.
   assign w_lock_hold = ahb_hlock[r_owner] | r_mastlock;
   assign w_hold      = (w_cnt_next != '0) | w_lock_hold;
   assign w_any_req   = |ahb_hbusreq;

   // Search order is rr_ptr+1 .. rr_ptr (wrapping). Iterating from the far end
   // back to the nearest lets the last hit be the first requester in order.
   always_comb begin
      w_winner = DEF_IDX;
      for (int unsigned d = NUM_MASTERS; d >= 1; d--) begin
         if (ahb_hbusreq[MIDX_W'((32'(r_rr_ptr) + d) % NUM_MASTERS)]) begin
            w_winner = MIDX_W'((32'(r_rr_ptr) + d) % NUM_MASTERS);
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (ahb_hready) begin
         if (w_lock_hold)
            w_state_next = ST_LOCK;
         else if (w_cnt_next != '0)
            w_state_next = ST_BURST;
         else if (ahb_hbusreq[r_owner])
            w_state_next = ST_OWN;
         else
            w_state_next = ST_PARK;
      end
   end

   always_ff @(posedge ahb_hclk) begin
      if (ahb_hreset) begin
         r_grant    <= DEF_GNT;
         r_owner    <= DEF_IDX;
         r_rr_ptr   <= DEF_IDX;
         r_cnt      <= '0;
         r_hmaster  <= DEF_IDX;
         r_mastlock <= 1'b0;
         r_state    <= ST_PARK;
      end else if (ahb_hready) begin
         r_cnt      <= w_cnt_next;
         r_hmaster  <= r_owner;
         r_mastlock <= ahb_hlock[r_owner];
         r_state    <= w_state_next;
         if (!w_hold) begin
            r_owner <= w_winner;
            r_grant <= NUM_MASTERS'(1) << w_winner;
            if (w_any_req) begin
               r_rr_ptr <= w_winner;
            end
         end
      end
   end

   assign ahb_hgrant    = r_grant;
   assign ahb_hmaster   = r_hmaster;
   assign ahb_hmastlock = r_mastlock;

   a_burst_has_beats: assert property (@(posedge ahb_hclk) disable iff (ahb_hreset)
      (r_state == ST_BURST) |-> (r_cnt != '0));

endmodule

// File: tb/tb_ahb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ahb_arbiter
//   Self-checking bench for ahb_arbiter (4 masters, default master 0).
//   The driver applies one cycle of stimulus per falling edge, steps a
//   behavioural arbiter model and queues the expected outputs; the monitor
//   pops and compares them after every rising edge.
// ----------------------------------------------------------------------------
module tb_ahb_arbiter;

   logic       clk;
   logic       rst;
   logic [3:0] busreq;
   logic [3:0] hlock;
   logic [1:0] htrans;
   logic [2:0] hburst;
   logic       hready;
   logic [3:0] grant;
   logic [1:0] hmaster;
   logic       mastlock;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [3:0] g;
      logic [1:0] m;
      logic       l;
      int         cyc;
   } exp_t;

   exp_t q[$];
   int   cyc_no = 0;

   // behavioural model state
   int m_owner;
   int m_am;
   int m_cnt;
   int m_rr;
   bit m_ml;

   ahb_arbiter #(
      .NUM_MASTERS   (4),
      .MIDX_W        (2),
      .DEFAULT_MASTER(0)
   ) dut (
      .ahb_hclk     (clk),
      .ahb_hreset   (rst),
      .ahb_hbusreq  (busreq),
      .ahb_hlock    (hlock),
      .ahb_htrans   (htrans),
      .ahb_hburst   (hburst),
      .ahb_hready   (hready),
      .ahb_hgrant   (grant),
      .ahb_hmaster  (hmaster),
      .ahb_hmastlock(mastlock)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int burst_beats(input logic [2:0] b);
      if (b == 3'd2 || b == 3'd3) return 4;
      if (b == 3'd4 || b == 3'd5) return 8;
      if (b >= 3'd6) return 16;
      return 1;
   endfunction

   // Apply one cycle of inputs and predict what the outputs show after the edge.
   task automatic cyc(input bit r, input logic [3:0] req, input logic [3:0] lk,
                      input logic [1:0] tr, input logic [2:0] bu, input bit rdy);
      int   next_cnt;
      bit   hold;
      exp_t e;
      @(negedge clk);
      rst    = r;
      busreq = req;
      hlock  = lk;
      htrans = tr;
      hburst = bu;
      hready = rdy;
      cyc_no++;
      if (r) begin
         m_owner = 0; m_am = 0; m_ml = 0; m_cnt = 0; m_rr = 0;
      end else if (rdy) begin
         case (tr)
            2'b10:   next_cnt = burst_beats(bu) - 1;
            2'b11:   next_cnt = (m_cnt > 0) ? m_cnt - 1 : 0;
            2'b00:   next_cnt = 0;
            default: next_cnt = m_cnt;
         endcase
         hold = (next_cnt != 0) || lk[m_owner] || m_ml;
         m_ml = lk[m_owner];
         m_am = m_owner;
         if (!hold) begin
            if (req == 4'b0000) begin
               m_owner = 0;
            end else begin
               for (int s = 1; s <= 4; s++) begin
                  if (req[(m_rr + s) % 4]) begin
                     m_owner = (m_rr + s) % 4;
                     m_rr    = m_owner;
                     break;
                  end
               end
            end
         end
         m_cnt = next_cnt;
      end
      e.g   = 4'b0001 << m_owner;
      e.m   = 2'(m_am);
      e.l   = m_ml;
      e.cyc = cyc_no;
      q.push_back(e);
   endtask

   // monitor / scoreboard
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            n_cmp++;
            if (grant !== e.g) begin
               n_err++;
               $display("FAIL grant cyc=%0d got=%b exp=%b", e.cyc, grant, e.g);
            end
            n_cmp++;
            if (hmaster !== e.m) begin
               n_err++;
               $display("FAIL hmaster cyc=%0d got=%0d exp=%0d", e.cyc, hmaster, e.m);
            end
            n_cmp++;
            if (mastlock !== e.l) begin
               n_err++;
               $display("FAIL hmastlock cyc=%0d got=%b exp=%b", e.cyc, mastlock, e.l);
            end
            n_cmp++;
            if ($countones(grant) != 1) begin
               n_err++;
               $display("FAIL onehot cyc=%0d got=%b exp=one bit set", e.cyc, grant);
            end
         end
      end
   end

   localparam logic [1:0] IDL = 2'b00, BSY = 2'b01, NSQ = 2'b10, SQ = 2'b11;
   localparam logic [2:0] SGL = 3'b000, INC = 3'b001, INC4 = 3'b011, INC8 = 3'b101;

   initial begin
      int wait_cnt;
      rst = 1'b1; busreq = 4'b1111; hlock = '0; htrans = IDL; hburst = SGL; hready = 1'b1;

      // reset with everyone requesting, then release
      cyc(1, 4'b1111, 4'b0000, IDL, SGL, 1);
      cyc(1, 4'b1111, 4'b0000, IDL, SGL, 1);
      cyc(0, 4'b0000, 4'b0000, IDL, SGL, 1);
      cyc(0, 4'b0000, 4'b0000, IDL, SGL, 1);

      // single requester, then it drops
      repeat (4) cyc(0, 4'b0100, 4'b0000, NSQ, SGL, 1);
      repeat (3) cyc(0, 4'b0000, 4'b0000, IDL, SGL, 1);

      // two-way rotation, plus INCR which must not hold
      repeat (6) cyc(0, 4'b0110, 4'b0000, NSQ, SGL, 1);
      repeat (4) cyc(0, 4'b0110, 4'b0000, NSQ, INC, 1);

      // master 1 INCR4 while master 3 waits
      cyc(0, 4'b0000, 4'b0000, IDL, SGL, 1);
      cyc(0, 4'b0010, 4'b0000, IDL, SGL, 1);
      cyc(0, 4'b0010, 4'b0000, IDL, SGL, 1);
      cyc(0, 4'b1010, 4'b0000, NSQ, INC4, 1);
      repeat (3) cyc(0, 4'b1010, 4'b0000, SQ, INC4, 1);
      repeat (2) cyc(0, 4'b1010, 4'b0000, NSQ, SGL, 1);

      // early termination by IDLE after two beats
      cyc(0, 4'b0010, 4'b0000, IDL, SGL, 1);
      repeat (2) cyc(0, 4'b0010, 4'b0000, IDL, SGL, 1);
      cyc(0, 4'b1010, 4'b0000, NSQ, INC4, 1);
      cyc(0, 4'b1010, 4'b0000, SQ, INC4, 1);
      cyc(0, 4'b1010, 4'b0000, IDL, SGL, 1);
      repeat (2) cyc(0, 4'b1010, 4'b0000, NSQ, SGL, 1);

      // wait states mid-burst with master 2 requesting, BUSY inside burst
      cyc(0, 4'b0010, 4'b0000, IDL, SGL, 1);
      repeat (2) cyc(0, 4'b0010, 4'b0000, IDL, SGL, 1);
      cyc(0, 4'b0110, 4'b0000, NSQ, INC4, 1);
      cyc(0, 4'b0110, 4'b0000, SQ, INC4, 1);
      repeat (3) cyc(0, 4'b1101, 4'b0000, SQ, INC4, 0);
      cyc(0, 4'b0110, 4'b0000, BSY, INC4, 1);
      repeat (2) cyc(0, 4'b0110, 4'b0000, SQ, INC4, 1);
      repeat (3) cyc(0, 4'b0110, 4'b0000, NSQ, SGL, 1);

      // INCR8 ended by IDLE while a new request arrives
      cyc(0, 4'b0001, 4'b0000, NSQ, INC8, 1);
      repeat (2) cyc(0, 4'b1001, 4'b0000, SQ, INC8, 1);
      cyc(0, 4'b1000, 4'b0000, IDL, SGL, 1);
      repeat (2) cyc(0, 4'b1000, 4'b0000, NSQ, SGL, 1);

      // master 2 locked for 5 transfers while master 0 requests
      repeat (2) cyc(0, 4'b0100, 4'b0100, IDL, SGL, 1);
      repeat (5) cyc(0, 4'b0101, 4'b0100, NSQ, SGL, 1);
      repeat (4) cyc(0, 4'b0101, 4'b0000, NSQ, SGL, 1);

      // reset in the middle of a lock
      repeat (2) cyc(0, 4'b0100, 4'b0100, NSQ, SGL, 1);
      repeat (2) cyc(0, 4'b0101, 4'b0100, NSQ, SGL, 1);
      cyc(1, 4'b0101, 4'b0100, NSQ, SGL, 1);
      repeat (3) cyc(0, 4'b0001, 4'b0000, NSQ, SGL, 1);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 149) == 0),
             4'($urandom),
             ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000,
             2'($urandom),
             3'($urandom),
             ($urandom_range(0, 3) != 0));
      end

      // let the monitor drain the queue, bounded
      wait_cnt = 0;
      while (q.size() > 0 && wait_cnt < 10) begin
         @(posedge clk);
         #2;
         wait_cnt++;
      end
      if (q.size() > 0) begin
         n_err++;
         $display("FAIL drain got=%0d pending exp=0 pending", q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ahb_arbiter.md
Name: ahb_arbiter

Overview:
- Round-robin AHB bus arbiter that shares the AHB bus between up to NUM_MASTERS requesters. Requesters include the edge detector's pixel-read and result-write masters, plus the external host.
- Drives the one-hot ahb_hgrant vector, plus the address-phase master index and master-lock signals that the bus interface and slave-side muxes consume.
- Honours fixed-length bursts, locked transfers and slave wait states (ahb_hready low).

Parameters:
NUM_MASTERS, 4, number of requesting masters (2..8)
MIDX_W, 2, width of master index; must equal ceil(log2(NUM_MASTERS))
DEFAULT_MASTER, 0, index granted at reset and when no master requests (bus parking)

Ports:
ahb_hclk  input  1  bus clock; all state updates on rising edge
ahb_hreset  input  1  reset, synchronous, active-high
ahb_hbusreq  input  NUM_MASTERS  per-master bus request
ahb_hlock  input  NUM_MASTERS  per-master locked-transfer request
ahb_htrans  input  2  transfer type of current address-phase master (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
ahb_hburst  input  3  burst type of current address-phase master (000 SINGLE, 001 INCR, 010/011 4-beat, 100/101 8-beat, 110/111 16-beat)
ahb_hready  input  1  slave ready; a transfer is accepted only in cycles where this is 1
ahb_hgrant  output  NUM_MASTERS  one-hot grant
ahb_hmaster  output  MIDX_W  index of master owning the address phase
ahb_hmastlock  output  1  current address-phase transfer is locked

Behaviour:
- Reset: when ahb_hreset=1 at a rising edge:
  - ahb_hgrant = one-hot(DEFAULT_MASTER); ahb_hmaster = DEFAULT_MASTER; ahb_hmastlock = 0.
  - Beat counter = 0; round-robin pointer = DEFAULT_MASTER; FSM = PARK.
  - Reset mid-burst or mid-lock discards all state, with no residual hold.
- Owner: the index of the currently granted master (encoded ahb_hgrant). Exactly one grant bit is high at all times.
- Beat counter (5 bits), updated only when ahb_hready=1:
  - NONSEQ loads len-1, where len = 4/8/16 for fixed bursts and len = 1 for SINGLE and INCR.
  - SEQ with count>0 decrements the counter.
  - IDLE clears it (early burst termination).
  - BUSY leaves it unchanged.
  - cnt_next is the combinational next value.
- Hold conditions: hold = (cnt_next != 0) OR ahb_hlock[owner] OR ahb_hmastlock.
  - The ahb_hmastlock term keeps the grant through the final locked transfer.
  - INCR bursts never hold.
- Rearbitration: occurs in a cycle only when ahb_hready=1 AND hold=0.
  - The winner is the first requesting index searching (rr_ptr+1) mod N upward, wrapping, and ending at rr_ptr inclusive. The owner wins again only if no other master requests.
  - If no bit of ahb_hbusreq is set, the winner is DEFAULT_MASTER.
  - ahb_hgrant is registered and shows the winner one cycle later.
  - rr_ptr <= winner whenever the winner was a requester.
- Address-phase ownership:
  - On a rising edge with ahb_hready=1: ahb_hmaster <= owner and ahb_hmastlock <= ahb_hlock[owner].
  - With ahb_hready=0, both hold.
  - This gives a one-cycle handover bubble between grant change and ownership change, which is accepted.
- While ahb_hready=0: grant, counter, hmaster, hmastlock and rr_ptr are all frozen, regardless of request changes.
- FSM states (the FSM is informational; outputs follow the rules above):
  - PARK: owner=DEFAULT, not requested.
  - OWN: owner requesting, no hold.
  - BURST: cnt>0.
  - LOCK: lock hold active.
  - Transitions are evaluated only on ahb_hready=1. LOCK has priority over BURST, BURST over OWN, and OWN over PARK.
- Simultaneous events:
  - IDLE plus a new request in the same cycle: the count clears and rearbitration uses the new request.
  - Requests from all masters: strict rotation, so no master starves beyond N-1 tenures.

Test Plan:
1. Reset: assert ahb_hreset 2 cycles with ahb_hbusreq=4'b1111 -> during and 1 cycle after, ahb_hgrant=4'b0001, ahb_hmaster=0, ahb_hmastlock=0.
2. Single requester: ahb_hbusreq=4'b0100, ahb_hready=1, SINGLE transfers -> ahb_hgrant=4'b0100 next cycle; ahb_hmaster=2 the cycle after; held while the request stays; returns to 4'b0001 one cycle after the request drops.
3. Round-robin: ahb_hbusreq=4'b0110, SINGLE NONSEQ every cycle, ahb_hready=1 -> grant alternates 0010, 0100, 0010... each cycle after the first handover.
4. Burst hold: master 1 owns and issues INCR4 (NONSEQ then 3 SEQ) while master 3 requests -> grant stays 4'b0010 through the 3rd SEQ acceptance and becomes 4'b1000 the following cycle. Repeat with IDLE after 2 beats -> handover right after the IDLE.
5. Wait states: during master 1's INCR4, hold ahb_hready=0 for 3 cycles mid-burst with master 2 requesting -> grant, ahb_hmaster and counter unchanged during the stall; burst completes with exactly 4 accepted beats before handover.
6. Lock: master 2 asserts ahb_hlock[2] and ahb_hbusreq[2] for 5 SINGLE transfers while master 0 requests -> ahb_hmastlock=1 for those transfers; grant held until one accepted transfer after ahb_hlock[2] falls; then 4'b0001. Assert ahb_hreset mid-lock -> immediate return to reset values.
